// File: rtl/udp_frame_send_if.sv
// udp_frame_send_if: DRAM reader request/data and UDP stream handshake.
// The master side is the frame sender, the slave side is the reader/stack.
interface udp_frame_send_if;
    logic        kick;
    logic        busy;
    logic [31:0] read_addr;
    logic [31:0] read_num;
    logic [31:0] buf_dout;
    logic        buf_we;
    logic        w_req;
    logic        w_ack;
    logic        w_enable;
    logic [31:0] w_data;

    modport master (
        output kick, read_addr, read_num, w_req, w_enable, w_data,
        input  busy, buf_dout, buf_we, w_ack
    );

    modport slave (
        input  kick, read_addr, read_num, w_req, w_enable, w_data,
        output busy, buf_dout, buf_we, w_ack
    );
endinterface

// File: rtl/udp_frame_send.sv
// udp_frame_send: reads one frame from DRAM chunk by chunk and streams each
// chunk as a packet of two header words plus PKT_WORDS pixel words.
module udp_frame_send #(
    parameter int unsigned X_SIZE     = 1600,
    parameter int unsigned Y_SIZE     = 900,
    parameter int unsigned PKT_WORDS  = 400,
    parameter logic [31:0] BASE_ADDR0 = 32'h0000_0000,
    parameter logic [31:0] BASE_ADDR1 = 32'h0100_0000
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    input  logic frame_select,
    output logic frame_done,
    output logic sending,
    output logic overrun,
    udp_frame_send_if.master bus
);
    localparam int unsigned NPKT = X_SIZE * Y_SIZE / PKT_WORDS;
    localparam int unsigned CW   = $clog2(PKT_WORDS + 1);
    localparam int unsigned AW   = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

    localparam logic [CW-1:0] FULL     = CW'(PKT_WORDS);
    localparam logic [AW-1:0] LAST     = AW'(PKT_WORDS - 1);
    localparam logic [15:0]   LAST_PKT = 16'(NPKT - 1);
    localparam logic [15:0]   PKT_LEN  = 16'(PKT_WORDS);
    localparam logic [31:0]   STRIDE   = 32'(PKT_WORDS * 4);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_KICK = 3'd1;
    localparam logic [2:0] S_FILL = 3'd2;
    localparam logic [2:0] S_REQ  = 3'd3;
    localparam logic [2:0] S_HDR0 = 3'd4;
    localparam logic [2:0] S_HDR1 = 3'd5;
    localparam logic [2:0] S_PAY  = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    logic [2:0]    state;
    logic [31:0]   base;
    logic [15:0]   pkt_idx;
    logic [15:0]   frame_cnt;
    logic [CW-1:0] wcnt;
    logic [AW-1:0] rcnt;
    logic [AW-1:0] raddr;
    logic [31:0]   rdata;
    logic [31:0]   mem [PKT_WORDS];
    logic          full;
    logic          store;

    assign full  = (wcnt == FULL);
    assign store = bus.buf_we && !full &&
                   ((state == S_KICK) || (state == S_FILL));

    // Read one word ahead so payload leaves the RAM with no bubble.
    assign raddr = ((state == S_PAY) && (rcnt != LAST)) ?
                   rcnt + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wcnt[AW-1:0]] <= bus.buf_dout;
        end
        rdata <= mem[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            base      <= '0;
            pkt_idx   <= '0;
            frame_cnt <= '0;
            wcnt      <= '0;
            rcnt      <= '0;
            overrun   <= 1'b0;
        end else begin
            if (store) begin
                wcnt <= wcnt + 1'b1;
            end
            if (bus.buf_we && full) begin
                overrun <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        base    <= frame_select ? BASE_ADDR1 : BASE_ADDR0;
                        pkt_idx <= '0;
                        state   <= S_KICK;
                    end
                end
                S_KICK: begin
                    if (bus.busy) begin
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (full && !bus.busy) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.w_ack) begin
                        state <= S_HDR0;
                    end
                end
                S_HDR0: begin
                    state <= S_HDR1;
                end
                S_HDR1: begin
                    rcnt  <= '0;
                    state <= S_PAY;
                end
                S_PAY: begin
                    rcnt <= rcnt + 1'b1;
                    if (rcnt == LAST) begin
                        wcnt    <= '0;
                        pkt_idx <= pkt_idx + 1'b1;
                        state   <= (pkt_idx == LAST_PKT) ? S_DONE : S_KICK;
                    end
                end
                S_DONE: begin
                    frame_cnt <= frame_cnt + 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.kick      = (state == S_KICK);
    assign bus.read_addr = bus.kick ? base + 32'(pkt_idx) * STRIDE : '0;
    assign bus.read_num  = bus.kick ? 32'(PKT_WORDS) : '0;
    assign bus.w_req     = (state == S_REQ);
    assign bus.w_enable  = (state == S_HDR0) || (state == S_HDR1) ||
                           (state == S_PAY);
    assign frame_done    = (state == S_DONE);
    assign sending       = (state != S_IDLE);

    always_comb begin
        bus.w_data = '0;
        unique case (state)
            S_HDR0:  bus.w_data = {8'hA5, 8'h00, frame_cnt};
            S_HDR1:  bus.w_data = {pkt_idx, PKT_LEN};
            S_PAY:   bus.w_data = rdata;
            default: bus.w_data = '0;
        endcase
    end
endmodule
